aes_inv_round_unit: RTL and testbench

Registered single-round AES-128 inverse-cipher datapath. Each accepted 128-bit state is transformed by InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns (InvMixColumns skipped on the final round). The result appears one clock later. It sits under the AES-128 decryption controller, which owns round sequencing, the initial AddRoundKey with rk10, and round-key selection.

---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/aes_inv_sbyte.sv | 23 ++
 rtl/aes_inv_round_unit.sv | 87 ++++++++
 tb/tb_aes_inv_round_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-round datapath: the state type,
// byte-index helpers and the GF(2^8) arithmetic used by InvSubBytes and
// InvMixColumns. Field polynomial is x^8+x^4+x^3+x+1, so the reduction
// constant is 8'h1B.
package aes_pkg;

  localparam logic [7:0] GF_RED = 8'h1B;

  typedef logic [127:0] aes_state_t;

  // Byte number of state element s[r][c] (column-major, byte 0 at the MSB end)
  function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
    return r + 4 * c;
  endfunction

  // Extract byte k of a state
  function automatic logic [7:0] get_byte(input aes_state_t s, input int unsigned k);
    return s[127 - 8 * k -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
  endfunction

  // General GF(2^8) product, shift-and-add over the bits of b
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; 0 maps to 0 naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) acc = gf_mul(gf_mul(acc, acc), a);
    return gf_mul(acc, acc);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/aes_inv_sbyte.sv
// Single-byte AES inverse S-box, computed rather than tabled: the inverse
// affine transform is undone first, then the GF(2^8) inverse is taken.
module aes_inv_sbyte
  import aes_pkg::*;
(
  input  logic [7:0] val,
  output logic [7:0] sub
);

  localparam logic [7:0] INV_AFF_C = 8'h05;

  logic [7:0] aff;

  // Inverse affine: bit i = b[i+2] ^ b[i+5] ^ b[i+7] ^ c[i], indices mod 8
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_aff
      assign aff[gi] = val[(gi + 2) % 8] ^ val[(gi + 5) % 8] ^ val[(gi + 7) % 8] ^ INV_AFF_C[gi];
    end
  endgenerate

  assign sub = gf_inv(aff);

endmodule

// File: rtl/aes_inv_round_unit.sv
// One registered AES-128 inverse-cipher round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns, with
// InvMixColumns bypassed when final_round is set. One cycle of latency,
// one block per cycle. Round sequencing and key selection live upstream.
// Optional define AES_INV_ROUND_TRACE_EN: prints each accepted round's
// intermediate values in simulation; cycle behaviour is unchanged.
module aes_inv_round_unit
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic         out_valid,
  output logic [127:0] state_out
);

  aes_state_t shifted;
  aes_state_t subbed;
  aes_state_t keyed;
  aes_state_t mixed;
  aes_state_t state_next;
  aes_state_t state_out_reg;
  logic       out_valid_reg;

  // InvShiftRows (row r moves right by r) and InvSubBytes per byte
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam int unsigned ROW = gi % 4;
      localparam int unsigned COL = gi / 4;
      localparam int unsigned SRC = byte_idx(ROW, (COL + 4 - ROW) % 4);

      assign shifted[127 - 8 * gi -: 8] = state_in[127 - 8 * SRC -: 8];

      aes_inv_sbyte u_sbyte (
        .val (shifted[127 - 8 * gi -: 8]),
        .sub (subbed[127 - 8 * gi -: 8])
      );
    end
  endgenerate

  assign keyed = subbed ^ round_key;

  // InvMixColumns: each column multiplied by the circulant {0e,0b,0d,09}
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = get_byte(keyed, byte_idx(0, gi));
      assign a1 = get_byte(keyed, byte_idx(1, gi));
      assign a2 = get_byte(keyed, byte_idx(2, gi));
      assign a3 = get_byte(keyed, byte_idx(3, gi));
      assign mixed[127 - 8 * (4 * gi + 0) -: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
      assign mixed[127 - 8 * (4 * gi + 1) -: 8] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
      assign mixed[127 - 8 * (4 * gi + 2) -: 8] = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
      assign mixed[127 - 8 * (4 * gi + 3) -: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
    end
  endgenerate

  assign state_next = final_round ? keyed : mixed;

  // Output registers: reset clears, idle cycles hold the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      state_out_reg <= '0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) state_out_reg <= state_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign state_out = state_out_reg;

`ifdef AES_INV_ROUND_TRACE_EN
  // Trace of every accepted round's intermediate values
  always_ff @(posedge clk) begin
    if (!rst && in_valid)
      $display("%0t inv_round in=%h shift=%h sub=%h key=%h mix=%h final=%0b",
               $time, state_in, shifted, subbed, keyed, mixed, final_round);
  end
`else
`endif

endmodule

// File: tb/tb_aes_inv_round_unit.sv
// Self-checking bench for aes_inv_round_unit. Expected results are queued
// when a block is driven and popped when out_valid shows a result.
module tb_aes_inv_round_unit;

  typedef struct packed {
    logic         chk;
    logic [127:0] val;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         final_round;
  logic         out_valid;
  logic [127:0] state_out;

  sb_t          sb_q[$];
  int           n_checks = 0;
  int           n_fails  = 0;
  logic [127:0] hold_ref;
  logic         hold_known;
  logic [127:0] rk [0:10];

  localparam logic [127:0] MID_IN   = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] MID_KEY  = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] MID_OUT  = 128'h54d990a16ba09ab596bbf40ea111702f;
  localparam logic [127:0] FIN_IN   = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] FIN_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PLAIN    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CIPHER   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_inv_round_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .state_in    (state_in),
    .round_key   (round_key),
    .final_round (final_round),
    .out_valid   (out_valid),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check the registered outputs 1 time unit after the edge
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [127:0] s, input logic [127:0] k, input logic f,
                      input logic c, input logic [127:0] e);
    sb_t ent;
    rst = r; in_valid = v; state_in = s; round_key = k; final_round = f;
    if (v && !r) sb_q.push_back('{chk: c, val: e});
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {127'h0, out_valid}, {127'h0, (v && !r)});
    if (r) begin
      sb_q.delete();
      check({tag, ".rst_state"}, state_out, 128'h0);
      hold_ref   = 128'h0;
      hold_known = 1'b1;
    end else if (out_valid) begin
      if (sb_q.size() == 0) begin
        check({tag, ".sb_empty"}, 128'h1, 128'h0);
      end else begin
        ent = sb_q.pop_front();
        if (ent.chk) begin
          check({tag, ".state"}, state_out, ent.val);
          hold_ref   = ent.val;
          hold_known = 1'b1;
        end else begin
          hold_known = 1'b0;
        end
      end
    end else if (hold_known) begin
      check({tag, ".hold"}, state_out, hold_ref);
    end
    $display("txn %s rst=%0b v=%0b final=%0b out_valid=%0b state_out=%h",
             tag, r, v, f, out_valid, state_out);
  endtask

  initial begin
    logic [127:0] cur;
    rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    hold_ref = 128'h0; hold_known = 1'b0;
    rst = 1'b1; in_valid = 1'b0; state_in = '0; round_key = '0; final_round = 1'b0;

    // Reset dominates in_valid, then idle after release keeps outputs at 0
    step("rst0", 1'b1, 1'b1, MID_IN, MID_KEY, 1'b0, 1'b0, '0);
    step("rst1", 1'b1, 1'b1, FIN_IN, FIN_KEY, 1'b1, 1'b0, '0);
    step("idle0", 1'b0, 1'b0, MID_IN, MID_KEY, 1'b0, 1'b0, '0);

    // Single middle and final rounds
    step("mid", 1'b0, 1'b1, MID_IN, MID_KEY, 1'b0, 1'b1, MID_OUT);
    step("idle1", 1'b0, 1'b0, 128'h0, 128'h0, 1'b1, 1'b0, '0);
    step("final", 1'b0, 1'b1, FIN_IN, FIN_KEY, 1'b1, 1'b1, PLAIN);

    // S-box corner bytes
    step("sb63", 1'b0, 1'b1, {16{8'h63}}, 128'h0, 1'b1, 1'b1, 128'h0);
    step("sb00", 1'b0, 1'b1, 128'h0, 128'h0, 1'b1, 1'b1, {16{8'h52}});

    // Back-to-back, then idle hold
    step("b2b0", 1'b0, 1'b1, MID_IN, MID_KEY, 1'b0, 1'b1, MID_OUT);
    step("b2b1", 1'b0, 1'b1, FIN_IN, FIN_KEY, 1'b1, 1'b1, PLAIN);
    step("idle2", 1'b0, 1'b0, MID_IN, MID_KEY, 1'b0, 1'b0, '0);
    step("idle3", 1'b0, 1'b0, FIN_IN, FIN_KEY, 1'b1, 1'b0, '0);

    // Reset mid-stream discards the block in flight
    step("ms0", 1'b0, 1'b1, MID_IN, MID_KEY, 1'b0, 1'b1, MID_OUT);
    step("msrst", 1'b1, 1'b1, FIN_IN, FIN_KEY, 1'b1, 1'b0, '0);
    step("ms1", 1'b0, 1'b0, FIN_IN, FIN_KEY, 1'b1, 1'b0, '0);

    // Full decrypt: controller model feeds each result into the next round
    cur = CIPHER ^ rk[10];
    for (int r = 1; r <= 10; r++) begin
      step($sformatf("dec%0d", r), 1'b0, 1'b1, cur, rk[10 - r], (r == 10),
           (r == 1) || (r == 10), (r == 1) ? MID_OUT : PLAIN);
      cur = state_out;
    end
    step("idle4", 1'b0, 1'b0, 128'h0, 128'h0, 1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
